// File: rtl/cv_weights_loader_if.sv
// Weight stream (valid/ready/last) plus buffer write port of the conv weights loader.
// The slave modport is the loader's view; master is the upstream/buffer side.
interface cv_weights_loader_if #(
    parameter int IN_W  = 64,
    parameter int ROW_W = 512,
    parameter int ADR_W = 11
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             wr_en;
    logic [ADR_W-1:0] wr_adr;
    logic [ROW_W-1:0] wr_data;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, wr_en, wr_adr, wr_data
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, wr_en, wr_adr, wr_data
    );
endinterface

// File: rtl/cv_weights_loader.sv
// Packs a valid/ready weight stream into ROW_W-bit buffer rows; 1-bit weights arrive
// one pair per byte and are re-densified. One registered write per completed row.
module cv_weights_loader #(
    parameter int IN_W    = 64,
    parameter int ROW_W   = 512,
    parameter int ADR_W   = 11,
    parameter int ADR_MAX = 2047
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               mode_i,
    input  logic               start_i,
    input  logic [ADR_W-1:0]   base_adr_i,
    cv_weights_loader_if.slave bus,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [ADR_W:0]     rows_written_o,
    output logic               fmt_warn_o
);
    localparam int NB     = IN_W / 8;
    localparam int SLOT1  = IN_W / 4;
    localparam int BEATS0 = ROW_W / IN_W;
    localparam int BEATS1 = ROW_W / SLOT1;
    localparam int BW     = $clog2(BEATS1);
    localparam logic [BW-1:0]    LAST0    = BW'(BEATS0 - 1);
    localparam logic [BW-1:0]    LAST1    = BW'(BEATS1 - 1);
    localparam logic [ADR_W-1:0] ADR_LAST = ADR_W'(ADR_MAX);

    typedef enum logic [1:0] {IDLE, FILL, ERR} state_t;
    state_t state_q, state_d;

    logic             mode_q, mode_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [ROW_W-1:0] acc_q, acc_d;
    logic [ADR_W:0]   rows_q, rows_d;
    logic             fmt_q, fmt_d;
    logic             err_q, err_d;
    logic             wr_en_q, wr_en_d;
    logic [ADR_W-1:0] wr_adr_q, wr_adr_d;
    logic [ROW_W-1:0] wr_data_q, wr_data_d;
    logic             done_q, done_d;

    logic             in_ready;
    logic             accept, start_ok, row_done;
    logic [SLOT1-1:0] dense;
    logic             bad_fmt;

    assign start_ok = start_i && (state_q != FILL);
    assign accept   = bus.in_valid && in_ready;
    assign row_done = accept && (bus.in_last || beat_q == (mode_q ? LAST1 : LAST0));

    // 1-bit mode: keep bits [1:0] of each byte; any set bit in [7:2] is a format warning
    always_comb begin
        dense   = '0;
        bad_fmt = 1'b0;
        for (int j = 0; j < NB; j++) begin
            dense[2*j +: 2] = bus.in_data[8*j +: 2];
            bad_fmt         = bad_fmt | (|bus.in_data[8*j+2 +: 6]);
        end
    end

    // FSM: state register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, ERR: if (start_i) state_d = FILL;
            FILL: begin
                if (row_done) begin
                    if (bus.in_last)          state_d = IDLE;
                    else if (adr_q == ADR_LAST) state_d = ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready = (state_q == FILL);
        busy_o   = (state_q != IDLE);
    end

    // Datapath next state
    always_comb begin
        mode_d    = mode_q;
        adr_d     = adr_q;
        beat_d    = beat_q;
        acc_d     = acc_q;
        rows_d    = rows_q;
        fmt_d     = fmt_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_adr_d  = wr_adr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        if (start_ok) begin
            mode_d = mode_i;
            adr_d  = base_adr_i;
            beat_d = '0;
            acc_d  = '0;
            rows_d = '0;
            fmt_d  = 1'b0;
            err_d  = 1'b0;
        end else if (accept) begin
            if (mode_q) begin
                acc_d[int'(beat_q)*SLOT1 +: SLOT1] = dense;
                fmt_d = fmt_q | bad_fmt;
            end else begin
                acc_d[int'(beat_q)*IN_W +: IN_W] = bus.in_data;
            end
            beat_d = beat_q + 1'b1;
            if (row_done) begin
                // acc was cleared after the previous row, so unused slots are already zero
                wr_en_d   = 1'b1;
                wr_adr_d  = adr_q;
                wr_data_d = acc_d;
                acc_d     = '0;
                beat_d    = '0;
                rows_d    = rows_q + 1'b1;
                done_d    = bus.in_last;
                if (adr_q != ADR_LAST) adr_d = adr_q + 1'b1;
                else if (!bus.in_last) err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mode_q    <= 1'b0;
            adr_q     <= '0;
            beat_q    <= '0;
            acc_q     <= '0;
            rows_q    <= '0;
            fmt_q     <= 1'b0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_adr_q  <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            adr_q     <= adr_d;
            beat_q    <= beat_d;
            acc_q     <= acc_d;
            rows_q    <= rows_d;
            fmt_q     <= fmt_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_adr_q  <= wr_adr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_adr     = wr_adr_q;
    assign bus.wr_data    = wr_data_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign rows_written_o = rows_q;
    assign fmt_warn_o     = fmt_q;
endmodule
